// File: rtl/mix_forward_ctrl.sv
// ---------------------------------------------------------------------------
// mix_forward_ctrl
//
// Sequencer for the mix-layer forward datapath. For each of N_ROWS token rows
// it pre-fetches input/weight/bias buffer addresses one cycle ahead of use,
// opens the datapath run window, and writes the finished row into the output
// buffer when the datapath count reaches VALID_C.
//
// Optional feature macro: MIX_CTRL_VALID_CHECK_EN
//   defined     : datapath `valid` is cross-checked against the internal count
//                 every RUN cycle; any disagreement sets a sticky `err`.
//   not defined : `err` stays 0 and `valid` has no effect.
//
// Handshake: `start` is a one-cycle request honoured only while IDLE (busy=0);
// `done` is a one-cycle completion pulse, and `busy` drops the cycle after it.
//
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a batch (ignored unless IDLE)
//   busy       : batch in progress
//   done       : one-cycle pulse after the last row is written
//   x_addr     : input buffer read address {row, chunk}
//   w_addr     : weight buffer read address
//   b_addr     : bias buffer read address
//   run        : datapath enable (low clears the datapath counters)
//   valid      : datapath result-ready flag
//   o_we       : output buffer write strobe
//   o_addr     : output buffer row address
//   err        : sticky valid/count disagreement flag
// ---------------------------------------------------------------------------
module mix_forward_ctrl #(
    parameter int N_ROWS  = 10,
    parameter int HID_DIM = 24,
    parameter int N_CHUNK = 4,
    parameter int ROW_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ROW_W+1:0] x_addr,
    output logic [6:0]       w_addr,
    output logic [4:0]       b_addr,
    output logic             run,
    input  logic             valid,
    output logic             o_we,
    output logic [ROW_W-1:0] o_addr,
    output logic             err
);

    localparam int VALID_C   = 4 * HID_DIM + 6;          // count at which the row result is valid
    localparam int LAST_W    = HID_DIM * N_CHUNK - 1;    // last weight address
    localparam int BIAS_LAST = 8 + 4 * (HID_DIM - 1);    // count that issues the last bias
    localparam int C_W       = $clog2(VALID_C + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [C_W-1:0]   c_q, c_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             run_q, run_d;
    logic             o_we_q, o_we_d;
    logic [ROW_W+1:0] x_addr_q, x_addr_d;
    logic [6:0]       w_addr_q, w_addr_d;
    logic [4:0]       b_addr_q, b_addr_d;
    logic [ROW_W-1:0] o_addr_q, o_addr_d;
    logic             err_q, err_d;

    logic [C_W-1:0]   c_plus1;
    logic [C_W-1:0]   bias_off;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    c_d     = '0;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                c_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                if (c_q == C_W'(VALID_C)) begin
                    c_d = '0;
                    if (row_q == ROW_W'(N_ROWS - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = PRIME;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Outputs are registered, so they are derived from the
    // *next* state/count: the value seen on a port during a cycle then
    // belongs to the state the FSM is in during that same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d   = (state_d != IDLE);
        run_d    = (state_d == RUN);
        done_d   = (state_d == DONE);
        o_we_d   = (state_d == RUN) && (c_d == C_W'(VALID_C));
        x_addr_d = x_addr_q;
        w_addr_d = w_addr_q;
        b_addr_d = b_addr_q;
        o_addr_d = o_addr_q;
        c_plus1  = c_d + 1'b1;
        bias_off = c_d - C_W'(8);

        if (state_d == PRIME) begin
            w_addr_d = '0;
            x_addr_d = {row_d, 2'b00};
        end

        // One-cycle lead: address for count c+1 is presented during count c.
        if ((state_d == RUN) && (c_d < C_W'(LAST_W))) begin
            w_addr_d = 7'(c_plus1);
            x_addr_d = {row_d, c_plus1[1:0]};
        end

        // Bias k is issued at count 8+4k and held until the next update.
        if ((state_d == RUN) && (c_d >= C_W'(8)) && (c_d[1:0] == 2'b00) &&
            (c_d <= C_W'(BIAS_LAST))) begin
            b_addr_d = 5'(bias_off >> 2);
        end

        if (o_we_d) begin
            o_addr_d = row_d;
        end
    end

`ifdef MIX_CTRL_VALID_CHECK_EN
    // valid must be high exactly at the result count of every RUN row.
    always_comb begin
        err_d = err_q;
        if ((state_q == RUN) && (valid != (c_q == C_W'(VALID_C)))) begin
            err_d = 1'b1;
        end
    end
`else
    // err_q resets to 0 and can never be set; valid is read here only so
    // it is not a dangling input.
    always_comb begin
        err_d = err_q & valid;
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
            o_we_q   <= 1'b0;
            x_addr_q <= '0;
            w_addr_q <= '0;
            b_addr_q <= '0;
            o_addr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            row_q    <= row_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            run_q    <= run_d;
            o_we_q   <= o_we_d;
            x_addr_q <= x_addr_d;
            w_addr_q <= w_addr_d;
            b_addr_q <= b_addr_d;
            o_addr_q <= o_addr_d;
            err_q    <= err_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign run    = run_q;
    assign o_we   = o_we_q;
    assign x_addr = x_addr_q;
    assign w_addr = w_addr_q;
    assign b_addr = b_addr_q;
    assign o_addr = o_addr_q;
    assign err    = err_q;

endmodule
